mem_system: RTL and testbench

//  Memory subsystem sitting directly downstream of the CPU memory port; it services every instruction

---
 rtl/mem_system_pkg.sv | 30 +++
 rtl/mem_timer.sv | 70 +++++++
 rtl/mem_system.sv | 101 ++++++++++
 tb/tb_mem_system.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_system_pkg.sv
// Shared memory-map constants for mem_system and the CPU's MMIO accesses:
// region bases, IO register offsets, CTRL/STATUS bit positions and decode helpers.
package mem_system_pkg;

  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] IO_BASE  = 32'hFFFF_FF00;

  localparam logic [7:0] LED_OFS    = 8'h00;
  localparam logic [7:0] COUNT_OFS  = 8'h10;
  localparam logic [7:0] RELOAD_OFS = 8'h14;
  localparam logic [7:0] CTRL_OFS   = 8'h18;
  localparam logic [7:0] STATUS_OFS = 8'h1C;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_AUTO_BIT  = 1;
  localparam int STATUS_EXP_BIT = 0;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_LED  = 2'd2,
    SEL_TMR  = 2'd3
  } sel_e;

  // Timer registers occupy the aligned words 0x10..0x1C of the IO page.
  function automatic logic is_tmr_ofs(input logic [7:0] ofs);
    return (ofs[7:4] == 4'h1) && (ofs[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_timer.sv
// Down-counting timer: COUNT/RELOAD/CTRL/STATUS registers with their write decode.
// Rule order per edge: RELOAD write, then decrement, then expiry (set beats W1C, CTRL write beats auto-clear).
module mem_timer
  import mem_system_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [7:0]  ofs,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] count;
  logic [31:0] reload;
  logic        en;
  logic        auto_rl;
  logic        expired;
  logic        reload_wr;
  logic        ctrl_wr;
  logic        status_wr;

  assign reload_wr = we && (ofs == RELOAD_OFS);
  assign ctrl_wr   = we && (ofs == CTRL_OFS);
  assign status_wr = we && (ofs == STATUS_OFS);
  assign irq       = expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      reload  <= '0;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      expired <= 1'b0;
    end else begin
      if (reload_wr) reload <= wdata;
      if (ctrl_wr) begin
        en      <= wdata[CTRL_EN_BIT];
        auto_rl <= wdata[CTRL_AUTO_BIT];
      end
      if (status_wr && wdata[STATUS_EXP_BIT]) expired <= 1'b0;

      if (reload_wr) begin
        count <= wdata;
      end else if (en && (count != 32'd0)) begin
        count <= count - 32'd1;
      end else if (en) begin
        expired <= 1'b1;
        if (auto_rl) count <= reload;
        else if (!ctrl_wr) en <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      COUNT_OFS:  rdata = count;
      RELOAD_OFS: rdata = reload;
      CTRL_OFS: begin
        rdata[CTRL_EN_BIT]   = en;
        rdata[CTRL_AUTO_BIT] = auto_rl;
      end
      STATUS_OFS: rdata[STATUS_EXP_BIT] = expired;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_system.sv
// CPU memory port target: RAM, LED register and timer behind one decoded address space.
// Reads are combinational; writes commit at the clock edge; bad accesses raise a one-cycle bus error.
module mem_system
  import mem_system_pkg::*;
#(
  parameter int    RAM_WORDS = 1024,
  parameter string INIT_FILE = "",
  parameter int    LED_W     = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [31:0]      iMemAddr,
  input  logic [31:0]      iMemData,
  input  logic             iMemRead,
  input  logic             iMemWrite,
  output logic [31:0]      oMemData,
  output logic [LED_W-1:0] oLED,
  output logic             oTimerIrq,
  output logic             oBusErr
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]      ram [RAM_WORDS];
  logic [AW-1:0]    ram_idx;
  logic [7:0]       io_ofs;
  sel_e             sel;
  logic             strobe;
  logic             bad;
  logic             wr_ok;
  logic [LED_W-1:0] led;
  logic [31:0]      led_rdata;
  logic [31:0]      tmr_rdata;
  logic             bus_err;

  assign ram_idx = iMemAddr[AW+1:2];
  assign io_ofs  = iMemAddr[7:0];
  assign strobe  = iMemRead | iMemWrite;

  always_comb begin
    sel = SEL_NONE;
    if (iMemAddr[1:0] != 2'b00) begin
      sel = SEL_NONE;
    end else if (iMemAddr[31:AW+2] == RAM_BASE[31:AW+2]) begin
      sel = SEL_RAM;
    end else if (iMemAddr[31:8] == IO_BASE[31:8]) begin
      if (io_ofs == LED_OFS) sel = SEL_LED;
      else if (is_tmr_ofs(io_ofs)) sel = SEL_TMR;
    end
  end

  // COUNT is read-only, so a write there is an error even though the address is mapped.
  assign bad   = strobe && ((sel == SEL_NONE) ||
                 (iMemWrite && (sel == SEL_TMR) && (io_ofs == COUNT_OFS)));
  assign wr_ok = iMemWrite && !bad;

  always_ff @(posedge iClk) begin
    if (wr_ok && (sel == SEL_RAM)) ram[ram_idx] <= iMemData;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      led     <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= bad;
      if (wr_ok && (sel == SEL_LED)) led <= iMemData[LED_W-1:0];
    end
  end

  mem_timer u_timer (
    .clk   (iClk),
    .rst   (iRst),
    .we    (wr_ok && (sel == SEL_TMR)),
    .ofs   (io_ofs),
    .wdata (iMemData),
    .rdata (tmr_rdata),
    .irq   (oTimerIrq)
  );

  always_comb begin
    led_rdata              = '0;
    led_rdata[LED_W-1:0]   = led;
  end

  always_comb begin
    oMemData = '0;
    if (iMemRead) begin
      case (sel)
        SEL_RAM: oMemData = ram[ram_idx];
        SEL_LED: oMemData = led_rdata;
        SEL_TMR: oMemData = tmr_rdata;
        default: oMemData = '0;
      endcase
    end
  end

  assign oLED    = led;
  assign oBusErr = bus_err;

endmodule

// File: tb/tb_mem_system.sv
// Directed and random stimulus for mem_system, checked against a register-level reference model.
module tb_mem_system;

  localparam int RAM_WORDS = 1024;
  localparam logic [31:0] A_LED    = 32'hFFFF_FF00;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_FF10;
  localparam logic [31:0] A_RELOAD = 32'hFFFF_FF14;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_FF18;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF1C;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [31:0] iMemAddr = '0;
  logic [31:0] iMemData = '0;
  logic        iMemRead = 1'b0;
  logic        iMemWrite = 1'b0;
  logic [31:0] oMemData;
  logic [7:0]  oLED;
  logic        oTimerIrq;
  logic        oBusErr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [7:0]  m_led;
  logic [31:0] m_count, m_reload;
  logic        m_en, m_auto, m_exp, m_berr;

  mem_system #(.RAM_WORDS(RAM_WORDS), .INIT_FILE(""), .LED_W(8)) dut (
    .iClk(iClk), .iRst(iRst), .iMemAddr(iMemAddr), .iMemData(iMemData),
    .iMemRead(iMemRead), .iMemWrite(iMemWrite), .oMemData(oMemData),
    .oLED(oLED), .oTimerIrq(oTimerIrq), .oBusErr(oBusErr)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_led = '0; m_count = '0; m_reload = '0;
    m_en = 1'b0; m_auto = 1'b0; m_exp = 1'b0; m_berr = 1'b0;
  endtask

  function automatic logic is_ram(input logic [31:0] a);
    return a < RAM_WORDS * 4;
  endfunction

  function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
    if (!rd || a[1:0] != 2'b00) return 32'h0;
    if (is_ram(a)) return m_ram[int'(a[31:2])];
    case (a)
      A_LED:    return {24'h0, m_led};
      A_COUNT:  return m_count;
      A_RELOAD: return m_reload;
      A_CTRL:   return {30'h0, m_auto, m_en};
      A_STATUS: return {31'h0, m_exp};
      default:  return 32'h0;
    endcase
  endfunction

  function automatic logic m_bad(input logic rd, input logic wr, input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (a[1:0] != 2'b00) return 1'b1;
    if (is_ram(a)) return 1'b0;
    if (a == A_LED || a == A_RELOAD || a == A_CTRL || a == A_STATUS) return 1'b0;
    if (a == A_COUNT) return wr;
    return 1'b1;
  endfunction

  task automatic m_edge(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic        bad, ok, rw, cw, sw;
    logic [31:0] n_count, n_reload;
    logic        n_en, n_auto, n_exp;
    bad = m_bad(rd, wr, a);
    ok  = wr && !bad;
    rw  = ok && a == A_RELOAD;
    cw  = ok && a == A_CTRL;
    sw  = ok && a == A_STATUS;
    if (ok && is_ram(a)) m_ram[int'(a[31:2])] = d;
    if (ok && a == A_LED) m_led = d[7:0];
    n_count = m_count; n_reload = rw ? d : m_reload;
    n_en = m_en; n_auto = m_auto; n_exp = m_exp;
    if (sw && d[0]) n_exp = 1'b0;
    if (cw) begin n_en = d[0]; n_auto = d[1]; end
    if (rw) n_count = d;
    else if (m_en && m_count != 0) n_count = m_count - 1;
    else if (m_en) begin
      n_exp = 1'b1;
      if (m_auto) n_count = m_reload;
      else if (!cw) n_en = 1'b0;
    end
    m_count = n_count; m_reload = n_reload; m_en = n_en; m_auto = n_auto; m_exp = n_exp;
    m_berr = bad;
  endtask

  // One bus cycle: entered just after a rising edge, returns just after the next one.
  task automatic cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] seen);
    iMemRead = rd; iMemWrite = wr; iMemAddr = a; iMemData = d;
    @(negedge iClk);
    seen = oMemData;
    check($sformatf("rdata@%h", a), oMemData, m_read(rd, a));
    check("led", {24'h0, oLED}, {24'h0, m_led});
    check("irq", {31'h0, oTimerIrq}, {31'h0, m_exp});
    check("buserr", {31'h0, oBusErr}, {31'h0, m_berr});
    @(posedge iClk);
    m_edge(rd, wr, a, d);
    #1;
  endtask

  logic [31:0] pool [12];
  logic [31:0] r;

  initial begin
    pool = '{32'h0, 32'h4, 32'h10, 32'h1C, A_LED, A_COUNT, A_RELOAD, A_CTRL, A_STATUS,
             32'h2, 32'h8000_0000, 32'hFFFF_FF04};
    m_reset();
    iMemRead = 1'b1; iMemAddr = A_COUNT;
    #2;
    check("rst_count", oMemData, 32'h0);
    check("rst_led", {24'h0, oLED}, 32'h0);
    check("rst_irq", {31'h0, oTimerIrq}, 32'h0);
    check("rst_buserr", {31'h0, oBusErr}, 32'h0);
    @(posedge iClk); #1;
    iRst = 1'b0;

    // RAM write, combinational read, idle read
    cycle(0, 1, 32'h0, 32'h1234_5678, r);
    cycle(1, 0, 32'h0, 32'h0, r);
    check("ram_word0", r, 32'h1234_5678);
    cycle(0, 0, 32'h0, 32'h0, r);
    check("rd_idle", r, 32'h0);

    // Read and write in the same cycle shows the old value
    cycle(0, 1, 32'h10, 32'hDEAD_BEEF, r);
    cycle(1, 1, 32'h10, 32'h0, r);
    check("rw_pre", r, 32'hDEAD_BEEF);
    cycle(1, 0, 32'h10, 32'h0, r);
    check("rw_post", r, 32'h0);

    // LED truncation
    cycle(0, 1, A_LED, 32'h1A5, r);
    cycle(1, 0, A_LED, 32'h0, r);
    check("led_rd", r, 32'h0000_00A5);
    check("led_out", {24'h0, oLED}, 32'hA5);

    // Auto-reload timer, W1C on the expiry edge
    cycle(0, 1, A_RELOAD, 32'd3, r);
    cycle(0, 1, A_CTRL, 32'd3, r);
    for (int i = 0; i < 12; i++) begin
      if (i == 3) begin
        cycle(1, 1, A_STATUS, 32'd1, r);
        check("status_pre", r, 32'h0);
        check("w1c_set_wins", {31'h0, oTimerIrq}, 32'h1);
      end else begin
        cycle(1, 0, A_COUNT, 32'h0, r);
        check("count_auto", r, 32'(3 - (i % 4)));
      end
    end
    cycle(0, 1, A_CTRL, 32'h0, r);
    cycle(0, 1, A_STATUS, 32'h1, r);
    check("irq_cleared", {31'h0, oTimerIrq}, 32'h0);

    // One-shot timer
    cycle(0, 1, A_RELOAD, 32'd2, r);
    cycle(0, 1, A_CTRL, 32'd1, r);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, A_COUNT, 32'h0, r);
      check("count_oneshot", r, (i < 3) ? 32'(2 - i) : 32'h0);
    end
    cycle(1, 0, A_CTRL, 32'h0, r);
    check("oneshot_en_off", r, 32'h0);
    check("oneshot_irq", {31'h0, oTimerIrq}, 32'h1);

    // Bad accesses
    cycle(0, 1, A_STATUS, 32'h1, r);
    cycle(0, 1, A_RELOAD, 32'd7, r);
    cycle(1, 0, 32'h0000_0002, 32'h0, r);
    check("misaligned_rd", r, 32'h0);
    check("misaligned_err", {31'h0, oBusErr}, 32'h1);
    cycle(0, 0, 32'h0, 32'h0, r);
    check("err_pulse_end", {31'h0, oBusErr}, 32'h0);
    cycle(1, 0, 32'h8000_0000, 32'h0, r);
    check("unmapped_rd", r, 32'h0);
    check("unmapped_err", {31'h0, oBusErr}, 32'h1);
    cycle(0, 0, 32'h0, 32'h0, r);
    cycle(0, 1, A_COUNT, 32'd5, r);
    check("count_wr_err", {31'h0, oBusErr}, 32'h1);
    cycle(1, 0, A_COUNT, 32'h0, r);
    check("count_unchanged", r, 32'd7);
    check("err_one_cycle", {31'h0, oBusErr}, 32'h0);

    // Random traffic
    for (int i = 0; i < 8; i++) cycle(0, 1, 32'(i * 4), $urandom, r);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d;
      a = pool[$urandom_range(0, 11)];
      d = (a == A_RELOAD) ? 32'($urandom_range(0, 5)) : $urandom;
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, d, r);
    end

    // Asynchronous reset mid-count
    cycle(0, 1, A_STATUS, 32'h1, r);
    cycle(0, 1, A_LED, 32'h5A, r);
    cycle(0, 1, A_RELOAD, 32'd3, r);
    cycle(0, 1, A_CTRL, 32'd3, r);
    for (int i = 0; i < 6; i++) cycle(0, 0, 32'h0, 32'h0, r);
    check("pre_rst_irq", {31'h0, oTimerIrq}, 32'h1);
    check("pre_rst_led", {24'h0, oLED}, 32'h5A);
    iMemRead = 1'b1; iMemWrite = 1'b1; iMemAddr = A_LED; iMemData = 32'hFF;
    #2;
    iRst = 1'b1;
    iMemWrite = 1'b0; iMemAddr = A_COUNT;
    #1;
    check("arst_led", {24'h0, oLED}, 32'h0);
    check("arst_irq", {31'h0, oTimerIrq}, 32'h0);
    check("arst_count", oMemData, 32'h0);
    m_reset();
    @(negedge iClk);
    iRst = 1'b0;
    @(posedge iClk); #1;
    cycle(1, 0, A_COUNT, 32'h0, r);
    check("post_rst_count", r, 32'h0);
    cycle(1, 0, A_LED, 32'h0, r);
    check("post_rst_led", r, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
